// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare/bimodal branch predictor.
package gshare_predictor_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } gshare_state_e;

    // Saturating counter step; holds at all-ones on taken and at zero on not-taken.
    function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                                 input logic        taken,
                                                 input int          width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 32'd1;
        end
        return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/gshare_predictor_pht_ram.sv
// Pattern history table storage: one combinational read port, one synchronous write port.
module gshare_predictor_pht_ram #(
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CTR_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [CTR_W-1:0] rdata
);

    // No reset on the array so it can map onto RAM; the clear walk initialises it.
    logic [CTR_W-1:0] mem_q [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch predictor with speculative history, mispredict repair
// and a table-clearing walk after reset or flush.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int PC_LSB   = 0,
    parameter int IDX_W    = 6,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 6,
    parameter int MODE     = 1,
    parameter int CTR_INIT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush_req,
    output logic              ready,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              lookup_taken,
    output logic [HIST_W-1:0] lookup_ghr,
    input  logic              update_valid,
    input  logic [PC_W-1:0]   update_pc,
    input  logic [HIST_W-1:0] update_ghr,
    input  logic              update_taken,
    input  logic              update_mispredict,
    output gshare_state_e     dbg_state
);

    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t make_idx(input logic [PC_W-1:0]   pc,
                                      input logic [HIST_W-1:0] hist);
        idx_t h;
        h = '0;
        if (MODE == MODE_GSHARE) begin
            h[HIST_W-1:0] = hist;
        end
        return pc[PC_LSB +: IDX_W] ^ h;
    endfunction

    gshare_state_e     state_q, state_d;
    idx_t              ptr_q, ptr_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;

    idx_t              lookup_idx, update_idx, pht_waddr;
    logic [CTR_W-1:0]  rd_lookup, rd_update, pht_wdata;
    logic              pht_we, look_fire, upd_fire, repair;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, update_pc};

    assign lookup_idx = make_idx(lookup_pc, ghr_q);
    assign update_idx = make_idx(update_pc, update_ghr);
    assign look_fire  = lookup_valid & ready;
    assign upd_fire   = update_valid & ready;
    assign repair     = upd_fire & update_mispredict;

    // Two identical copies give the lookup and the read-modify-write update their own read port.
    gshare_predictor_pht_ram #(.IDX_W(IDX_W), .CTR_W(CTR_W)) pht_lookup (
        .clk(clk), .we(pht_we), .waddr(pht_waddr), .wdata(pht_wdata),
        .raddr(lookup_idx), .rdata(rd_lookup)
    );

    gshare_predictor_pht_ram #(.IDX_W(IDX_W), .CTR_W(CTR_W)) pht_update (
        .clk(clk), .we(pht_we), .waddr(pht_waddr), .wdata(pht_wdata),
        .raddr(update_idx), .rdata(rd_update)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (flush_req) begin
                    ptr_d = '0;
                end else if (ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_INIT;
                    ptr_d   = '0;
                    ghr_d   = '0;
                end else if (repair) begin
                    // Repair restores the branch's own history, overriding any lookup shift.
                    ghr_d = HIST_W'({update_ghr, update_taken});
                end else if (look_fire) begin
                    ghr_d = HIST_W'({ghr_q, lookup_taken});
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ready        = (state_q == ST_RUN);
        lookup_taken = ready & rd_lookup[CTR_W-1];
        lookup_ghr   = ghr_q;
        dbg_state    = state_q;
        if (state_q == ST_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = ptr_q;
            pht_wdata = CTR_W'(CTR_INIT);
        end else begin
            pht_we    = upd_fire;
            pht_waddr = update_idx;
            pht_wdata = CTR_W'(sat_ctr_next(32'(rd_update), update_taken, CTR_W));
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a gshare and a bimodal instance share stimulus and
// are compared against a table-level reference model.
module tb_gshare_predictor;
  import gshare_predictor_pkg::*;

  localparam int DEPTH = 64;
  localparam int CMAX  = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_req;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [5:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;

  logic          ready_g, ready_b, lt_g, lt_b;
  logic [5:0]    ghr_g, ghr_b;
  gshare_state_e st_g, st_b;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: index 0 = bimodal, 1 = gshare
  int m_pht [2][DEPTH];
  int m_ghr [2];
  bit m_rdy;
  int m_walk;

  always #5 clk = ~clk;

  gshare_predictor #(.MODE(1)) dut_g (
    .clk(clk), .reset_n(reset_n), .flush_req(flush_req), .ready(ready_g),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_taken(lt_g),
    .lookup_ghr(ghr_g), .update_valid(update_valid), .update_pc(update_pc),
    .update_ghr(update_ghr), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .dbg_state(st_g)
  );

  gshare_predictor #(.MODE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush_req(flush_req), .ready(ready_b),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_taken(lt_b),
    .lookup_ghr(ghr_b), .update_valid(update_valid), .update_pc(update_pc),
    .update_ghr(update_ghr), .update_taken(update_taken),
    .update_mispredict(update_mispredict), .dbg_state(st_b)
  );

  function automatic int m_idx(input int m, input logic [31:0] pc, input int hist);
    int base;
    base = int'(pc % 32'd64);
    return (m == 1) ? (base ^ hist) : base;
  endfunction

  function automatic bit m_pred(input int m, input logic [31:0] pc);
    return m_rdy && (m_pht[m][m_idx(m, pc, m_ghr[m])] >= 2);
  endfunction

  task automatic model_reset();
    m_rdy = 1'b0;
    m_walk = 0;
    m_ghr[0] = 0;
    m_ghr[1] = 0;
  endtask

  task automatic model_step();
    bit lt [2];
    int i;
    if (!reset_n) return;
    if (!m_rdy) begin
      if (flush_req) m_walk = 0;
      else begin
        m_pht[0][m_walk] = 0;
        m_pht[1][m_walk] = 0;
        m_walk++;
        if (m_walk == DEPTH) m_rdy = 1'b1;
      end
    end else begin
      for (int m = 0; m < 2; m++) lt[m] = m_pred(m, lookup_pc);
      if (update_valid) begin
        for (int m = 0; m < 2; m++) begin
          i = m_idx(m, update_pc, int'(update_ghr));
          if (update_taken && m_pht[m][i] < CMAX) m_pht[m][i]++;
          if (!update_taken && m_pht[m][i] > 0) m_pht[m][i]--;
        end
      end
      if (flush_req) begin
        model_reset();
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (update_valid && update_mispredict)
            m_ghr[m] = (int'(update_ghr) * 2 + int'(update_taken)) % 64;
          else if (lookup_valid)
            m_ghr[m] = (m_ghr[m] * 2 + int'(lt[m])) % 64;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush_req = 0; lookup_valid = 0; lookup_pc = 0; update_valid = 0;
    update_pc = 0; update_ghr = 0; update_taken = 0; update_mispredict = 0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready_g !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== 64 || ready_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s walk_cycles got=%0d ready_b=%b exp=64 ready_b=1", name, n, ready_b);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ready_g, ready_b} !== 2'b00 || st_g !== ST_INIT) begin
      tests_failed++;
      $display("FAIL reset_ready got=%b%b state=%0d exp=00 state=%0d", ready_g, ready_b, st_g, ST_INIT);
    end
    tests_run++;
    if (ghr_g !== 6'd0 || ghr_b !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_ghr got=%h/%h exp=00/00", ghr_g, ghr_b);
    end
    reset_n = 1;
    wait_ready("reset_release");
    for (int k = 0; k < 16; k++) begin
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_pc = $urandom_range(0, 1023);
      #1;
      tests_run++;
      if (lt_g !== 1'b0 || lt_b !== 1'b0) begin
        tests_failed++;
        $display("FAIL cleared_predict pc=%0d got=%b/%b exp=0/0", lookup_pc, lt_g, lt_b);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_bimodal();
    bit outcome [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    bit exp_pred [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    idle_inputs();
    lookup_pc = 5;
    for (int k = 0; k < 10; k++) begin
      update_valid = 1; update_pc = 5; update_ghr = 0; update_taken = outcome[k];
      step();
      update_valid = 0;
      #1;
      tests_run++;
      if (lt_b !== exp_pred[k] || lt_g !== exp_pred[k]) begin
        tests_failed++;
        $display("FAIL bimodal_sat step=%0d got=%b/%b exp=%b", k, lt_b, lt_g, exp_pred[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_repair();
    idle_inputs();
    lookup_valid = 1; lookup_pc = 9;
    #1;
    tests_run++;
    if (lt_g !== 1'b0) begin
      tests_failed++;
      $display("FAIL repair_pre_pred got=%b exp=0", lt_g);
    end
    step();
    tests_run++;
    if (ghr_g !== 6'd0) begin
      tests_failed++;
      $display("FAIL repair_shift0 got=%b exp=000000", ghr_g);
    end
    update_valid = 1; update_mispredict = 1; update_ghr = 6'b101010;
    update_taken = 1; update_pc = 9;
    step();
    idle_inputs();
    tests_run++;
    if (ghr_g !== 6'b010101 || ghr_b !== 6'b010101) begin
      tests_failed++;
      $display("FAIL repair_wins got=%b/%b exp=010101", ghr_g, ghr_b);
    end
    // gshare index 5^21 is untrained, bimodal index 5 is weakly taken
    lookup_valid = 1; lookup_pc = 5;
    step();
    idle_inputs();
    tests_run++;
    if (ghr_g !== 6'b101010 || ghr_b !== 6'b101011) begin
      tests_failed++;
      $display("FAIL lookup_shift got=%b/%b exp=101010/101011", ghr_g, ghr_b);
    end
  endtask

  task automatic test_gshare_index();
    idle_inputs();
    update_valid = 1; update_mispredict = 1; update_ghr = 6'b000001;
    update_taken = 1; update_pc = 3;
    step();
    update_mispredict = 0; update_ghr = 6'b000011;
    repeat (2) step();
    idle_inputs();
    lookup_pc = 3;
    #1;
    tests_run++;
    if (lt_g !== 1'b1 || ghr_g !== 6'b000011) begin
      tests_failed++;
      $display("FAIL gshare_idx0 got=%b ghr=%b exp=1 ghr=000011", lt_g, ghr_g);
    end
    lookup_pc = 0;
    #1;
    tests_run++;
    if (lt_g !== 1'b0 || lt_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL gshare_idx3 got=%b/%b exp=0/0", lt_g, lt_b);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    bit saw_ready;
    int bad;
    idle_inputs();
    flush_req = 1;
    step();
    flush_req = 0;
    tests_run++;
    if (ready_g !== 1'b0 || ready_b !== 1'b0 || ghr_g !== 6'd0 || ghr_b !== 6'd0) begin
      tests_failed++;
      $display("FAIL flush_drop got=%b%b ghr=%b/%b exp=00 ghr=0", ready_g, ready_b, ghr_g, ghr_b);
    end
    saw_ready = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ready_g || ready_b) saw_ready = 1;
    end
    tests_run++;
    if (saw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_walk_ready got=1 exp=0");
    end
    flush_req = 1;
    step();
    flush_req = 0;
    wait_ready("flush_restart");
    bad = 0;
    for (int pc = 0; pc < DEPTH; pc++) begin
      lookup_pc = pc;
      #1;
      if (lt_g !== 1'b0 || lt_b !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL flush_cleared got=%0d taken entries exp=0", bad);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    idle_inputs();
    update_valid = 1; update_mispredict = 1; update_ghr = 6'b111000; update_taken = 1;
    update_pc = $urandom_range(0, 255);
    step();
    tests_run++;
    if (ghr_g !== 6'b110001) begin
      tests_failed++;
      $display("FAIL midop_setup got=%b exp=110001", ghr_g);
    end
    update_mispredict = 0;
    #2 reset_n = 0;
    #1;
    model_reset();
    tests_run++;
    if (ready_g !== 1'b0 || ready_b !== 1'b0 || ghr_g !== 6'd0 || ghr_b !== 6'd0) begin
      tests_failed++;
      $display("FAIL async_reset_update got=%b%b ghr=%b/%b exp=00 ghr=0", ready_g, ready_b, ghr_g, ghr_b);
    end
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
    wait_ready("reset_after_update");
    flush_req = 1;
    step();
    flush_req = 0;
    repeat (20) step();
    #2 reset_n = 0;
    #1;
    model_reset();
    tests_run++;
    if (ready_g !== 1'b0 || ghr_g !== 6'd0 || st_g !== ST_INIT) begin
      tests_failed++;
      $display("FAIL async_reset_walk got=%b ghr=%b exp=0 ghr=0", ready_g, ghr_g);
    end
    @(negedge clk);
    reset_n = 1;
    wait_ready("reset_after_walk");
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    for (int k = 0; k < 600; k++) begin
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_pc = $urandom_range(0, 255);
      update_valid = 1'($urandom_range(0, 1));
      update_pc = $urandom_range(0, 255);
      update_ghr = 6'($urandom_range(0, 63));
      update_taken = 1'($urandom_range(0, 1));
      update_mispredict = ($urandom_range(0, 3) == 0);
      flush_req = ($urandom_range(0, 199) == 0);
      #1;
      got = {ready_g, lt_g, ghr_g, ready_b, lt_b, ghr_b};
      exp = {m_rdy, m_pred(1, lookup_pc), 6'(m_ghr[1]), m_rdy, m_pred(0, lookup_pc), 6'(m_ghr[0])};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random cycle=%0d got=%h exp=%h", k, got, exp);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++) m_pht[m][i] = 0;
    test_reset();
    test_bimodal();
    test_repair();
    test_gshare_index();
    test_flush();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
